// File: rtl/dbn_pkg.sv
// Shared DBN layer definitions: default geometry, FSM states, input modes and
// the saturating accumulate used by the layer accumulator.
package dbn_pkg;

  localparam int unsigned DEF_N_NEU   = 16;
  localparam int unsigned DEF_CHUNK_W = 256;
  localparam int unsigned DEF_ACC_W   = 32;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_OUT
  } state_e;

  localparam logic MODE_AND  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  // Operands arrive sign-extended to 64 bits; w is the target signed width (<= 63).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w,
                                                 output logic sat);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = 1'b0;
    if (s > hi) begin
      s   = hi;
      sat = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      sat = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/dbn_layer_accum_if.sv
// Beat input and result output handshake bundle of the DBN layer accumulator.
interface dbn_layer_accum_if #(
  parameter int unsigned N_NEU   = 16,
  parameter int unsigned CHUNK_W = 256,
  parameter int unsigned ACC_W   = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [CHUNK_W-1:0]       in_data;
  logic [N_NEU*CHUNK_W-1:0] in_weight;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_NEU*ACC_W-1:0]   out_sum;
  logic [N_NEU-1:0]         out_act;
  logic [N_NEU-1:0]         out_sat;

  modport master (
    output in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_sum, out_act, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_sum, out_act, out_sat
  );
endinterface

// File: rtl/dbn_popcount_lane.sv
// One neuron lane: binary match count of a data/weight chunk, registered as a
// signed partial sum (AND: 0..CHUNK_W, XNOR: -CHUNK_W..+CHUNK_W).
module dbn_popcount_lane
  import dbn_pkg::*;
#(
  parameter int unsigned CHUNK_W = DEF_CHUNK_W,
  parameter int unsigned ACC_W   = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_mode,
  input  logic [CHUNK_W-1:0]      i_d,
  input  logic [CHUNK_W-1:0]      i_w,
  output logic signed [ACC_W-1:0] o_partial
);
  localparam int unsigned PC_W = $clog2(CHUNK_W + 1);

  logic [CHUNK_W-1:0]      w_bits;
  logic [PC_W-1:0]         w_pc;
  logic signed [ACC_W-1:0] w_partial;

  always_comb begin
    w_bits = (i_mode == MODE_XNOR) ? ~(i_d ^ i_w) : (i_d & i_w);
    w_pc   = '0;
    for (int unsigned k = 0; k < CHUNK_W; k++) begin
      w_pc = w_pc + PC_W'(w_bits[k]);
    end
    // Bipolar dot product: matches minus mismatches = 2*matches - CHUNK_W.
    if (i_mode == MODE_XNOR) begin
      w_partial = ACC_W'({w_pc, 1'b0}) - ACC_W'(CHUNK_W);
    end else begin
      w_partial = ACC_W'(w_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_partial <= '0;
    end else if (i_en) begin
      o_partial <= w_partial;
    end
  end
endmodule

// File: rtl/dbn_layer_accum.sv
// Streaming N_NEU-lane binary dot-product accumulator for one DBN hidden layer:
// bias-initialised saturating sums, binary activations and sticky saturation flags.
module dbn_layer_accum
  import dbn_pkg::*;
#(
  parameter int unsigned N_NEU   = DEF_N_NEU,
  parameter int unsigned CHUNK_W = DEF_CHUNK_W,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [CNT_W-1:0]       n_chunks,
  input  logic [N_NEU*ACC_W-1:0] bias,
  output logic                   busy,
  dbn_layer_accum_if.slave       bus
);
  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_nch;
  logic                    r_mode;
  logic                    r_pvalid;
  logic signed [ACC_W-1:0] r_acc     [N_NEU];
  logic signed [ACC_W-1:0] w_partial [N_NEU];
  logic signed [ACC_W-1:0] w_acc_nxt [N_NEU];
  logic signed [ACC_W-1:0] w_bias    [N_NEU];
  logic [N_NEU-1:0]        w_sat;
  logic [N_NEU-1:0]        r_sat;
  logic [N_NEU-1:0]        r_act;
  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_launch;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_cnt + CNT_W'(1)) == r_nch;
  assign w_launch = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (n_chunks == '0) ? ST_DRAIN : ST_ACCUM;
      ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_OUT;
      ST_OUT:   if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == ST_ACCUM) && (r_cnt < r_nch);
    w_out_valid = (r_state == ST_OUT);
    w_busy      = (r_state != ST_IDLE);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign busy          = w_busy;
  assign bus.out_act   = r_act;
  assign bus.out_sat   = r_sat;

  for (genvar g = 0; g < N_NEU; g++) begin : g_lane
    dbn_popcount_lane #(
      .CHUNK_W (CHUNK_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (w_accept),
      .i_mode    (r_mode),
      .i_d       (bus.in_data),
      .i_w       (bus.in_weight[g*CHUNK_W +: CHUNK_W]),
      .o_partial (w_partial[g])
    );
    assign w_bias[g]                       = bias[g*ACC_W +: ACC_W];
    assign bus.out_sum[g*ACC_W +: ACC_W]   = r_acc[g];
  end

  always_comb begin
    w_sat = '0;
    for (int unsigned i = 0; i < N_NEU; i++) begin
      w_acc_nxt[i] = ACC_W'(sat_add(64'(r_acc[i]), 64'(w_partial[i]), ACC_W, w_sat[i]));
    end
  end

  // Stage 2 adds a partial only on the edge after its beat was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_nch    <= '0;
      r_mode   <= MODE_AND;
      r_pvalid <= 1'b0;
      r_sat    <= '0;
      r_act    <= '0;
      for (int unsigned i = 0; i < N_NEU; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      r_pvalid <= w_accept;
      if (w_launch) begin
        r_mode <= mode;
        r_nch  <= n_chunks;
        r_cnt  <= '0;
        r_sat  <= '0;
        for (int unsigned i = 0; i < N_NEU; i++) begin
          r_acc[i] <= w_bias[i];
          r_act[i] <= !w_bias[i][ACC_W-1] && (w_bias[i] != '0);
        end
      end else begin
        if (w_accept) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (r_pvalid) begin
          for (int unsigned i = 0; i < N_NEU; i++) begin
            r_acc[i] <= w_acc_nxt[i];
            r_sat[i] <= r_sat[i] | w_sat[i];
            r_act[i] <= !w_acc_nxt[i][ACC_W-1] && (w_acc_nxt[i] != '0);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dbn_layer_accum.sv
// Directed bench for dbn_layer_accum: a 16-lane ACC_W=32 instance and a 2-lane
// ACC_W=10 instance for saturation, checked against a plain-arithmetic model.
module tb_dbn_layer_accum;
  localparam int NN  = 16;
  localparam int CW  = 256;
  localparam int AW  = 32;
  localparam int SN  = 2;
  localparam int SAW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              m_start, m_mode, m_busy;
  logic [7:0]        m_nch;
  logic [NN*AW-1:0]  m_bias;
  logic              s_start, s_mode, s_busy;
  logic [7:0]        s_nch;
  logic [SN*SAW-1:0] s_bias;

  dbn_layer_accum_if #(.N_NEU(NN), .CHUNK_W(CW), .ACC_W(AW))  ifm ();
  dbn_layer_accum_if #(.N_NEU(SN), .CHUNK_W(CW), .ACC_W(SAW)) ifs ();

  dbn_layer_accum #(.N_NEU(NN), .CHUNK_W(CW), .ACC_W(AW), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(m_start), .mode(m_mode), .n_chunks(m_nch),
    .bias(m_bias), .busy(m_busy), .bus(ifm)
  );

  dbn_layer_accum #(.N_NEU(SN), .CHUNK_W(CW), .ACC_W(SAW), .CNT_W(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .n_chunks(s_nch),
    .bias(s_bias), .busy(s_busy), .bus(ifs)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [CW-1:0]     bq_d[$];
  logic [NN*CW-1:0]  bq_w[$];
  longint            bias_v[NN];
  logic [NN*AW-1:0]  exp_sum;
  logic [NN-1:0]     exp_act, exp_sat;
  logic [SN*SAW-1:0] sexp_sum;
  logic [SN-1:0]     sexp_act, sexp_sat;

  task automatic chk(input string nm, input logic [599:0] a, input logic [599:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Sum of per-beat dot products on top of the bias, clamped after every beat.
  function automatic longint model_lane(input int lane, input int accw, input logic m,
                                        output logic sat);
    longint s, hi, lo;
    int pc;
    logic [CW-1:0] w;
    hi  = (longint'(1) <<< (accw - 1)) - 1;
    lo  = -hi - 1;
    s   = bias_v[lane];
    sat = 1'b0;
    foreach (bq_d[k]) begin
      w  = bq_w[k][lane*CW +: CW];
      pc = m ? $countones(~(bq_d[k] ^ w)) : $countones(bq_d[k] & w);
      s += m ? (2 * pc - CW) : pc;
      if (s > hi) begin s = hi; sat = 1'b1; end
      else if (s < lo) begin s = lo; sat = 1'b1; end
    end
    return s;
  endfunction

  function automatic logic [NN*CW-1:0] rvec();
    logic [NN*CW-1:0] r;
    for (int k = 0; k < NN*CW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic fill_rand(input int n);
    logic [NN*CW-1:0] t;
    bq_d.delete();
    bq_w.delete();
    for (int k = 0; k < n; k++) begin
      t = rvec();
      bq_d.push_back(t[CW-1:0]);
      bq_w.push_back(rvec());
    end
    for (int i = 0; i < NN; i++) bias_v[i] = longint'($urandom_range(0, 2000)) - 1000;
  endtask

  task automatic main_pass(input logic m, input int n, input bit gaps, input int hold,
                           input int abort_at, input bit hs_start);
    int acc_cnt, budget;
    bit v, acc;
    longint s;
    logic st;
    for (int i = 0; i < NN; i++) begin
      s = model_lane(i, AW, m, st);
      exp_sum[i*AW +: AW] = s[AW-1:0];
      exp_act[i] = (s > 0);
      exp_sat[i] = st;
      m_bias[i*AW +: AW] = bias_v[i][AW-1:0];
    end
    m_mode = m; m_nch = n[7:0]; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    acc_cnt = 0; budget = 0;
    while (acc_cnt < n && budget < 200) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifm.in_valid  = v;
      ifm.in_data   = v ? bq_d[acc_cnt] : ~bq_d[acc_cnt];
      ifm.in_weight = v ? bq_w[acc_cnt] : ~bq_w[acc_cnt];
      acc = v && ifm.in_ready;
      @(posedge clk); #1;
      if (acc) acc_cnt++;
      budget++;
      if (abort_at != 0 && acc_cnt == abort_at) begin
        rst_n = 1'b0;
        #2;
        chk("rst_abort", {ifm.out_valid, ifm.in_ready, m_busy, ifm.out_sum, ifm.out_act, ifm.out_sat}, '0);
        rst_n = 1'b1;
        ifm.in_valid = 1'b0;
        return;
      end
    end
    ifm.in_valid = 1'b0;
    chk("beats_accepted", acc_cnt, n);
    chk("lat_early", ifm.out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_valid", ifm.out_valid, 1'b1);
    repeat (hold) begin @(posedge clk); #1; end
    ifm.out_ready = 1'b1;
    m_start = hs_start;
    @(posedge clk); #1;
    ifm.out_ready = 1'b0;
    m_start = 1'b0;
    chk("idle_after", {ifm.out_valid, m_busy}, '0);
  endtask

  task automatic small_pass(input logic m, input int n);
    longint s;
    logic st;
    int b;
    for (int i = 0; i < SN; i++) begin
      s = model_lane(i, SAW, m, st);
      sexp_sum[i*SAW +: SAW] = s[SAW-1:0];
      sexp_act[i] = (s > 0);
      sexp_sat[i] = st;
      s_bias[i*SAW +: SAW] = bias_v[i][SAW-1:0];
    end
    s_mode = m; s_nch = n[7:0]; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk("s_in_ready", ifs.in_ready, 1'b1);
      ifs.in_valid  = 1'b1;
      ifs.in_data   = bq_d[k];
      ifs.in_weight = bq_w[k][SN*CW-1:0];
      @(posedge clk); #1;
    end
    ifs.in_valid = 1'b0;
    b = 0;
    while (!ifs.out_valid && b < 6) begin @(posedge clk); #1; b++; end
    chk("s_latency", b, 1);
    chk("s_sum", ifs.out_sum, sexp_sum);
    chk("s_act", ifs.out_act, sexp_act);
    chk("s_sat", ifs.out_sat, sexp_sat);
    ifs.out_ready = 1'b1;
    @(posedge clk); #1;
    ifs.out_ready = 1'b0;
    chk("s_idle", {ifs.out_valid, s_busy}, '0);
  endtask

  // Every cycle the main result is presented: model match, hold stability, no intake.
  logic                     prev_hold = 1'b0;
  logic [NN*AW+2*NN-1:0]    prev_out;
  always @(negedge clk) begin
    if (rst_n && ifm.out_valid) begin
      chk("out_sum", ifm.out_sum, exp_sum);
      chk("out_act", ifm.out_act, exp_act);
      chk("out_sat", ifm.out_sat, exp_sat);
      chk("in_ready_in_out", ifm.in_ready, 1'b0);
      if (prev_hold) chk("out_stable", {ifm.out_sum, ifm.out_act, ifm.out_sat}, prev_out);
    end
    prev_hold <= rst_n && ifm.out_valid && !ifm.out_ready;
    prev_out  <= {ifm.out_sum, ifm.out_act, ifm.out_sat};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0]    ones, one, d;
    logic [NN*CW-1:0] w;
    ones = '1;
    one  = 1;
    rst_n = 1'b0;
    m_start = 1'b0; m_mode = 1'b0; m_nch = '0; m_bias = '0;
    s_start = 1'b0; s_mode = 1'b0; s_nch = '0; s_bias = '0;
    ifm.in_valid = 1'b0; ifm.in_data = '0; ifm.in_weight = '0; ifm.out_ready = 1'b0;
    ifs.in_valid = 1'b0; ifs.in_data = '0; ifs.in_weight = '0; ifs.out_ready = 1'b0;
    #12;
    chk("rst_main", {ifm.out_valid, ifm.in_ready, m_busy, ifm.out_sum, ifm.out_act, ifm.out_sat}, '0);
    chk("rst_small", {ifs.out_valid, ifs.in_ready, s_busy, ifs.out_sum, ifs.out_act, ifs.out_sat}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // AND, 7 beats, lane i weight has i+1 ones
    bq_d.delete(); bq_w.delete();
    for (int i = 0; i < NN; i++) begin
      bias_v[i] = 0;
      w[i*CW +: CW] = (one << (i + 1)) - one;
    end
    for (int k = 0; k < 7; k++) begin bq_d.push_back(ones); bq_w.push_back(w); end
    main_pass(1'b0, 7, 1'b0, 0, 0, 1'b0);
    chk("pin_and_l0", exp_sum[AW-1:0], 32'd7);
    chk("pin_and_l15", exp_sum[15*AW +: AW], 32'd112);
    chk("pin_and_act", exp_act, 16'hFFFF);

    // XNOR, 2 beats, lane0 all match, lane1 all mismatch
    w = rvec();
    w[CW-1:0] = ones;
    w[2*CW-1:CW] = '0;
    bq_d.delete(); bq_w.delete();
    for (int k = 0; k < 2; k++) begin bq_d.push_back(ones); bq_w.push_back(w); end
    main_pass(1'b1, 2, 1'b0, 0, 0, 1'b0);
    chk("pin_xnor_l0", exp_sum[AW-1:0], 32'd512);
    chk("pin_xnor_l1", exp_sum[2*AW-1:AW], 32'hFFFF_FE00);
    chk("pin_xnor_act", exp_act[1:0], 2'b01);

    // Zero-length pass returns the bias
    bq_d.delete(); bq_w.delete();
    for (int i = 0; i < NN; i++) bias_v[i] = -5;
    main_pass(1'b0, 0, 1'b0, 0, 0, 1'b0);
    chk("pin_zero_l0", exp_sum[AW-1:0], 32'hFFFF_FFFB);
    chk("pin_zero_act", {exp_act, exp_sat}, '0);

    // Random data with in_valid gaps and a held result; start during handshake ignored
    fill_rand(7);
    main_pass(1'b0, 7, 1'b1, 5, 0, 1'b0);
    fill_rand(5);
    main_pass(1'b1, 5, 1'b1, 2, 0, 1'b1);

    // Reset after 3 of 7 beats, then a clean pass
    fill_rand(7);
    main_pass(1'b1, 7, 1'b0, 0, 3, 1'b0);
    @(posedge clk); #1;
    fill_rand(7);
    main_pass(1'b1, 7, 1'b1, 1, 0, 1'b0);

    // ACC_W=10: lane0 saturates high, lane1 saturates then falls back (sticky flag)
    w = rvec();
    d = w[CW-1:0];
    bq_d.delete(); bq_w.delete();
    for (int k = 0; k < 2; k++) begin
      w[CW-1:0] = d;
      w[2*CW-1:CW] = (k == 0) ? d : ~d;
      bq_d.push_back(d);
      bq_w.push_back(w);
    end
    bias_v[0] = 500; bias_v[1] = 500;
    small_pass(1'b1, 2);
    chk("pin_sat_sum", sexp_sum, {10'd255, 10'd511});
    chk("pin_sat_flags", {sexp_sat, sexp_act}, 4'b1111);

    // Next pass starts with saturation flags cleared
    w = '0;
    w[CW-1:0] = 256'h7;
    bq_d.delete(); bq_w.delete();
    bq_d.push_back(ones); bq_w.push_back(w);
    bias_v[0] = 0; bias_v[1] = 0;
    small_pass(1'b0, 1);
    chk("pin_clear_sum", sexp_sum, {10'd0, 10'd3});
    chk("pin_clear_flags", {sexp_sat, sexp_act}, 4'b0001);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
